// File: rtl/textbuf_apb_writer.sv
// APB3 slave giving the CPU cursor-based access to the VGA text character
// buffer: register file, one-wait-state cell reads and a hardware clear sweep.
module textbuf_apb_writer #(
  parameter  int unsigned CHARACTER_SET_COUNT = 20,
  parameter  int unsigned COLS                = 80,
  parameter  int unsigned ROWS                = 60,
  localparam int unsigned CHAR_W              = $clog2(CHARACTER_SET_COUNT),
  localparam int unsigned CELLS               = COLS * ROWS,
  localparam int unsigned ADDR_W              = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [4:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              buf_en,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [CHAR_W-1:0] buf_wdata,
  input  logic [CHAR_W-1:0] buf_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_CLEAR
  } state_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_CURSOR = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_FILL   = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [CHAR_W-1:0] fill_q, fill_d;
  logic              autoinc_q, autoinc_d;

  logic              access;
  logic [2:0]        reg_idx;
  logic              busy;
  logic              cursor_ok;
  logic [ADDR_W-1:0] cursor_next;
  logic              unused_paddr;

  assign access       = psel & penable;
  assign reg_idx      = paddr[4:2];
  assign busy         = (state_q == S_CLEAR);
  assign cursor_ok    = (pwdata < 32'(CELLS));
  assign cursor_next  = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
  assign unused_paddr = ^paddr[1:0];

  // APB response and buffer port are decoded combinationally from state and
  // bus so register and DATA-write accesses complete with zero wait states.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    count_d   = count_q;
    fill_d    = fill_q;
    autoinc_d = autoinc_q;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    buf_en    = 1'b0;
    buf_we    = 1'b0;
    buf_addr  = '0;
    buf_wdata = '0;

    // Non-DATA registers answer immediately, even while a clear is running.
    if (access && (reg_idx != REG_DATA) && (state_q != S_RD_WAIT)) begin
      pready = 1'b1;
      case (reg_idx)
        REG_CTRL: begin
          if (pwrite) begin
            autoinc_d = pwdata[1];
            if (pwdata[0] && !busy) begin
              state_d = S_CLEAR;
              count_d = '0;
            end
          end else begin
            prdata = {30'b0, autoinc_q, 1'b0};
          end
        end
        REG_CURSOR: begin
          if (pwrite) begin
            if (cursor_ok) cursor_d = pwdata[ADDR_W-1:0];
            else           pslverr  = 1'b1;
          end else begin
            prdata = 32'(cursor_q);
          end
        end
        REG_STATUS: begin
          if (!pwrite) prdata = {31'b0, busy};
        end
        REG_FILL: begin
          if (pwrite) fill_d = pwdata[CHAR_W-1:0];
          else        prdata = 32'(fill_q);
        end
        default: pslverr = 1'b1;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (access && (reg_idx == REG_DATA)) begin
          buf_en   = 1'b1;
          buf_addr = cursor_q;
          if (pwrite) begin
            buf_we    = 1'b1;
            buf_wdata = pwdata[CHAR_W-1:0];
            pready    = 1'b1;
            if (autoinc_q) cursor_d = cursor_next;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        state_d = S_IDLE;
        if (access) begin
          pready = 1'b1;
          prdata = 32'(buf_rdata);
          if (autoinc_q) cursor_d = cursor_next;
        end
      end
      S_CLEAR: begin
        buf_en    = 1'b1;
        buf_we    = 1'b1;
        buf_addr  = count_q;
        buf_wdata = fill_q;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_CELL) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cursor_q  <= '0;
      count_q   <= '0;
      fill_q    <= '0;
      autoinc_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      count_q   <= count_d;
      fill_q    <= fill_d;
      autoinc_q <= autoinc_d;
    end
  end

endmodule

// File: tb/tb_textbuf_apb_writer.sv
// Bench for textbuf_apb_writer: cycle-level expectation model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_textbuf_apb_writer;

  localparam int unsigned CSC     = 20;
  localparam int unsigned COLS    = 80;
  localparam int unsigned ROWS    = 60;
  localparam int unsigned CELLS   = COLS * ROWS;
  localparam int unsigned CHAR_W  = $clog2(CSC);
  localparam int unsigned ADDR_W  = $clog2(CELLS);
  localparam int unsigned TIMEOUT = 6000;

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_CURSOR = 5'h04;
  localparam logic [4:0] A_DATA   = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C;
  localparam logic [4:0] A_FILL   = 5'h10;
  localparam logic [4:0] A_BAD    = 5'h14;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic              psel    = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite  = 1'b0;
  logic [4:0]        paddr   = '0;
  logic [31:0]       pwdata  = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              buf_en;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [CHAR_W-1:0] buf_wdata;
  logic [CHAR_W-1:0] buf_rdata = '0;

  textbuf_apb_writer #(
    .CHARACTER_SET_COUNT(CSC),
    .COLS               (COLS),
    .ROWS               (ROWS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .buf_en   (buf_en),
    .buf_we   (buf_we),
    .buf_addr (buf_addr),
    .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Text buffer with one-cycle read latency; contents survive reset.
  logic [CHAR_W-1:0] tb_buf [CELLS] = '{default: '0};
  always @(posedge clk) begin
    if (buf_en === 1'b1 && buf_addr < ADDR_W'(CELLS)) begin
      if (buf_we === 1'b1) tb_buf[buf_addr] <= buf_wdata;
      else                 buf_rdata        <= tb_buf[buf_addr];
    end
  end

  int unsigned we_total = 0;
  always @(negedge clk) begin
    if (buf_en === 1'b1 && buf_we === 1'b1) we_total++;
  end

  // Expectation model: register values, expected buffer contents, remaining
  // clear cycles and an outstanding-read marker.
  logic [CHAR_W-1:0] m_mem [CELLS] = '{default: '0};
  int unsigned m_cursor = 0, m_fill = 0, m_clear_left = 0, m_rd_addr = 0;
  bit          m_auto = 1'b1, m_rd_pending = 1'b0;

  function automatic int unsigned inc_wrap(input int unsigned c);
    return (c + 1 == CELLS) ? 0 : c + 1;
  endfunction

  always begin : cmp
    bit          acc, e_rdy, e_err, e_en, e_we, n_auto, n_rdp, do_wr;
    logic [2:0]  a;
    int unsigned e_addr, e_wd, e_rd, n_cursor, n_fill, n_clear, n_rd_addr, wr_addr, wr_val;
    @(negedge clk);
    acc = psel && penable;
    a   = paddr[4:2];
    e_rdy = 0; e_err = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_rd = 0;
    n_cursor = m_cursor; n_fill = m_fill; n_clear = m_clear_left; n_auto = m_auto;
    n_rdp = m_rd_pending; n_rd_addr = m_rd_addr; do_wr = 0; wr_addr = 0; wr_val = 0;
    if (rst_n) begin
      if (acc && a != 3'd2 && !m_rd_pending) begin
        e_rdy = 1;
        case (a)
          3'd0: if (pwrite) begin
                  n_auto = pwdata[1];
                  if (pwdata[0] && m_clear_left == 0) n_clear = CELLS;
                end else e_rd = m_auto ? 32'd2 : 32'd0;
          3'd1: if (pwrite) begin
                  if (pwdata < CELLS) n_cursor = pwdata;
                  else                e_err = 1;
                end else e_rd = m_cursor;
          3'd3: if (!pwrite) e_rd = (m_clear_left != 0) ? 32'd1 : 32'd0;
          3'd4: if (pwrite) n_fill = 32'(pwdata[CHAR_W-1:0]);
                else        e_rd = m_fill;
          default: e_err = 1;
        endcase
      end
      if (m_clear_left != 0) begin
        e_en = 1; e_we = 1; e_addr = CELLS - m_clear_left; e_wd = m_fill;
        do_wr = 1; wr_addr = e_addr; wr_val = m_fill;
        n_clear = m_clear_left - 1;
      end else if (m_rd_pending) begin
        n_rdp = 0;
        if (acc) begin
          e_rdy = 1;
          e_rd  = 32'(m_mem[m_rd_addr[ADDR_W-1:0]]);
          if (m_auto) n_cursor = inc_wrap(m_cursor);
        end
      end else if (acc && a == 3'd2) begin
        e_en = 1; e_addr = m_cursor;
        if (pwrite) begin
          e_we = 1; e_wd = 32'(pwdata[CHAR_W-1:0]); e_rdy = 1;
          do_wr = 1; wr_addr = m_cursor; wr_val = e_wd;
          if (m_auto) n_cursor = inc_wrap(m_cursor);
        end else begin
          n_rdp = 1; n_rd_addr = m_cursor;
        end
      end
    end
    chk1("pready", pready, e_rdy);
    chk1("pslverr", pslverr, e_err);
    chk1("buf_en", buf_en, e_en);
    chk1("buf_we", buf_we, e_we);
    if (e_rdy && !pwrite) chk("prdata", prdata, e_rd);
    if (e_en) chk("buf_addr", 32'(buf_addr), e_addr);
    if (e_we) chk("buf_wdata", 32'(buf_wdata), e_wd);
    if (!rst_n) begin
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_buf_addr", 32'(buf_addr), 32'd0);
      chk("rst_buf_wdata", 32'(buf_wdata), 32'd0);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_cursor = 0; m_fill = 0; m_clear_left = 0; m_auto = 1; m_rd_pending = 0; m_rd_addr = 0;
    end else begin
      if (do_wr) m_mem[wr_addr[ADDR_W-1:0]] = wr_val[CHAR_W-1:0];
      m_cursor = n_cursor; m_fill = n_fill; m_clear_left = n_clear; m_auto = n_auto;
      m_rd_pending = n_rdp; m_rd_addr = n_rd_addr;
    end
  end

  logic [31:0] rd_v;
  bit          err_v;
  int unsigned waits_v;

  task automatic apb(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output bit err, output int unsigned waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; rd = '0; err = 1'b0;
    forever begin
      @(negedge clk);
      if (pready === 1'b1) begin
        rd  = prdata;
        err = pslverr;
        break;
      end
      waits++;
      if (waits > TIMEOUT) begin
        errors++;
        $display("FAIL apb_timeout: pready stuck at %b for addr %0h, required 1 within %0d cycles",
                 pready, addr, TIMEOUT);
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    apb(1'b1, addr, data, rd_v, err_v, waits_v);
  endtask

  task automatic rd(input logic [4:0] addr);
    apb(1'b0, addr, 32'd0, rd_v, err_v, waits_v);
  endtask

  initial begin : stim
    int unsigned we_base;
    int unsigned clears_left;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    rd(A_CURSOR); chk("reset_cursor", rd_v, 32'd0); chk("reset_cursor_waits", waits_v, 32'd0);
    rd(A_CTRL);   chk("reset_ctrl", rd_v, 32'd2);
    rd(A_STATUS); chk("reset_status", rd_v, 32'd0);

    // Cursor wrap with auto-increment
    wr(A_CURSOR, 32'd4798);
    wr(A_DATA, 32'd5); wr(A_DATA, 32'd6); wr(A_DATA, 32'd7);
    chk("wrap_w4798", 32'(tb_buf[4798]), 32'd5);
    chk("wrap_w4799", 32'(tb_buf[4799]), 32'd6);
    chk("wrap_w0", 32'(tb_buf[0]), 32'd7);
    rd(A_CURSOR); chk("wrap_cursor", rd_v, 32'd1);

    // Read-back with one wait state, with and without auto-increment
    wr(A_CURSOR, 32'd10); wr(A_DATA, 32'd3); wr(A_CURSOR, 32'd10);
    rd(A_DATA);   chk("rdback_data", rd_v, 32'd3); chk("rdback_waits", waits_v, 32'd1);
    rd(A_CURSOR); chk("rdback_cursor_inc", rd_v, 32'd11);
    wr(A_CTRL, 32'd0); wr(A_CURSOR, 32'd10);
    rd(A_DATA);   chk("rdback_noinc_data", rd_v, 32'd3);
    rd(A_CURSOR); chk("rdback_cursor_noinc", rd_v, 32'd10);
    wr(A_CTRL, 32'd2);

    // Clear sweep with a stalled DATA write behind it
    wr(A_FILL, 32'd2);
    we_base = we_total;
    wr(A_CTRL, 32'd3);
    rd(A_STATUS); chk("clear_busy", rd_v, 32'd1); chk("clear_status_waits", waits_v, 32'd0);
    wr(A_DATA, 32'd9);
    chk("clear_data_waits", waits_v, 32'd4795);
    chk("clear_we_cycles", we_total - we_base, 32'd4801);
    chk("clear_cell0", 32'(tb_buf[0]), 32'd2);
    chk("clear_cell4799", 32'(tb_buf[4799]), 32'd2);
    chk("clear_cell11", 32'(tb_buf[11]), 32'd2);
    chk("clear_then_write", 32'(tb_buf[10]), 32'd9);
    rd(A_STATUS); chk("clear_done", rd_v, 32'd0);
    rd(A_CURSOR); chk("clear_cursor", rd_v, 32'd11);

    // Error responses
    wr(A_CURSOR, 32'd4800); chk("cursor_oob_err", 32'(err_v), 32'd1);
    rd(A_BAD);              chk("unmapped_rd_err", 32'(err_v), 32'd1); chk("unmapped_rd", rd_v, 32'd0);
    wr(A_BAD, 32'hFFFF_FFFF); chk("unmapped_wr_err", 32'(err_v), 32'd1);
    rd(A_CURSOR);           chk("cursor_unchanged", rd_v, 32'd11);

    // Reset in the middle of a clear
    wr(A_FILL, 32'd7);
    wr(A_CTRL, 32'd3);
    repeat (100) @(posedge clk);
    #1 chk1("midclear_we", buf_we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("async_rst_buf_en", buf_en, 1'b0);
    chk1("async_rst_buf_we", buf_we, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(A_STATUS); chk("post_rst_status", rd_v, 32'd0);
    rd(A_CURSOR); chk("post_rst_cursor", rd_v, 32'd0);
    chk("partial_clear_cell50", 32'(tb_buf[50]), 32'd7);

    // Random traffic
    clears_left = 2;
    for (int i = 0; i < 400; i++) begin
      d = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: apb(1'($urandom_range(0, 1)), A_DATA, d, rd_v, err_v, waits_v);
        4, 9: begin
          case ($urandom_range(0, 3))
            0: d = $urandom_range(0, CELLS - 1);
            1: d = $urandom_range(CELLS - 3, CELLS + 2);
            2: d = $urandom_range(0, 100);
            default: ;
          endcase
          apb(1'($urandom_range(0, 1)), A_CURSOR, d, rd_v, err_v, waits_v);
        end
        5: begin
          d[0] = (clears_left != 0) && ($urandom_range(0, 29) == 0);
          if (d[0]) clears_left--;
          apb(1'($urandom_range(0, 1)), A_CTRL, d, rd_v, err_v, waits_v);
        end
        6: apb(1'b0, A_STATUS, d, rd_v, err_v, waits_v);
        7: apb(1'($urandom_range(0, 1)), A_FILL, d, rd_v, err_v, waits_v);
        default: apb(1'($urandom_range(0, 1)), 5'(8'h14 + 4 * $urandom_range(0, 2)),
                     d, rd_v, err_v, waits_v);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
